acc_register: RTL and testbench



---
 rtl/acc_pkg.sv | 22 ++
 rtl/acc_register_if.sv | 30 +++
 rtl/acc_shift_ctrl.sv | 102 ++++++++++
 rtl/acc_register.sv | 113 +++++++++++
 tb/tb_acc_register.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator register.
//   - 4-bit opcodes applied on the `ty` input. Codes 10..15 have no name and act as HOLD.
//   - State encoding for the multi-cycle shift sequencer.
package acc_pkg;

    localparam logic [3:0] CLEAR   = 4'd0;
    localparam logic [3:0] LOAD    = 4'd1;
    localparam logic [3:0] HOLD    = 4'd2;
    localparam logic [3:0] SHIFTR  = 4'd3;
    localparam logic [3:0] SHIFTL  = 4'd4;
    localparam logic [3:0] ASHR    = 4'd5;
    localparam logic [3:0] ROTR    = 4'd6;
    localparam logic [3:0] ROTL    = 4'd7;
    localparam logic [3:0] SHIFTRN = 4'd8;
    localparam logic [3:0] SHIFTLN = 4'd9;

    typedef enum logic {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_t;

endpackage

// File: rtl/acc_register_if.sv
// acc_register_if: groups the accumulator's datapath-facing signals.
//   master (ALU/control side) drives: ty, ulaout, shamt, serial_in
//   slave  (acc_register)     drives: acumulador, carry, zero, busy, done
// serial_in only matters when ACC_SERIAL_IN_EN is defined for the design.
interface acc_register_if #(
    parameter int WIDTH = 4
);
    localparam int SHW = $clog2(WIDTH + 1);

    logic [3:0]       ty;
    logic [WIDTH-1:0] ulaout;
    logic [SHW-1:0]   shamt;
    logic             serial_in;
    logic [WIDTH-1:0] acumulador;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output ty, ulaout, shamt, serial_in,
        input  acumulador, carry, zero, busy, done
    );

    modport slave (
        input  ty, ulaout, shamt, serial_in,
        output acumulador, carry, zero, busy, done
    );

endinterface

// File: rtl/acc_shift_ctrl.sv
// acc_shift_ctrl: sequencer for the SHIFTRN/SHIFTLN multi-cycle shifts.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   start           a shift-by-N opcode is presented while idle
//   dir_left_in     requested direction (1 = left), latched on accept
//   shamt           requested amount; values above WIDTH are clamped
//   abort           CLEAR presented while shifting
//   shift_en        the datapath shifts one bit on this edge
//   shift_left      direction to use for the shift on this edge
//   busy, done      registered handshake outputs
module acc_shift_ctrl
    import acc_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int SHW   = $clog2(WIDTH + 1)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic           dir_left_in,
    input  logic [SHW-1:0] shamt,
    input  logic           abort,
    output logic           shift_en,
    output logic           shift_left,
    output logic           busy,
    output logic           done
);

    state_t         state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [SHW-1:0] n_clamped;
    logic           dir_q, dir_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    assign n_clamped = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;

    // cnt_q holds the number of shifts still owed after the current edge;
    // the first shift happens on the accept edge itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d = dir_left_in;
                    if (n_clamped >= SHW'(2)) begin
                        shift_en = 1'b1;
                        cnt_d    = n_clamped - SHW'(1);
                        state_d  = SHIFTING;
                    end else begin
                        shift_en = (n_clamped == SHW'(1));
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFTING: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    shift_en = 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - SHW'(1);
                    end
                end
            end
        endcase
        busy_d = (state_d == SHIFTING);
    end

    // On the accept edge the direction comes straight from the opcode;
    // afterwards the latched copy is used so ty changes cannot redirect it.
    assign shift_left = (state_q == SHIFTING) ? dir_q : dir_left_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/acc_register.sv
// acc_register: CPU accumulator with clear/load/hold, single-bit shifts and
// rotates, and a multi-cycle shift-by-N with busy/done handshake.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   bus (slave)     ty, ulaout, shamt, serial_in in;
//                   acumulador, carry, zero, busy, done out
// Configuration: define ACC_SERIAL_IN_EN to fill the vacated bit of the
// logical shifts (SHIFTR/SHIFTL/SHIFTRN/SHIFTLN) with serial_in instead of 0.
module acc_register
    import acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    acc_register_if.slave bus
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sn_acc;
    logic             sn_carry;
    logic             fill;
    logic             is_shift_n;
    logic             start, abort;
    logic             shift_en, shift_left;
    logic             busy, done;

`ifdef ACC_SERIAL_IN_EN
    assign fill = bus.serial_in;
`else
    logic unused_serial_in;
    assign fill             = 1'b0;
    assign unused_serial_in = bus.serial_in;
`endif

    assign is_shift_n = (bus.ty == SHIFTRN) || (bus.ty == SHIFTLN);
    assign start      = is_shift_n && !busy;
    assign abort      = busy && (bus.ty == CLEAR);

    acc_shift_ctrl #(.WIDTH(WIDTH)) u_shift_ctrl (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dir_left_in (bus.ty == SHIFTLN),
        .shamt       (bus.shamt),
        .abort       (abort),
        .shift_en    (shift_en),
        .shift_left  (shift_left),
        .busy        (busy),
        .done        (done)
    );

    // One logical step of a shift-by-N, in the sequencer's chosen direction.
    always_comb begin
        if (shift_left) begin
            {sn_carry, sn_acc} = {acc_q, fill};
        end else begin
            {sn_acc, sn_carry} = {fill, acc_q};
        end
    end

    // While the sequencer is busy only CLEAR is honoured; otherwise the
    // opcode is decoded normally.
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (abort) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (shift_en) begin
            acc_d   = sn_acc;
            carry_d = sn_carry;
        end else if (!busy) begin
            case (bus.ty)
                CLEAR: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                end
                LOAD: begin
                    acc_d   = bus.ulaout;
                    carry_d = 1'b0;
                end
                HOLD: ;
                SHIFTR: {acc_d, carry_d} = {fill, acc_q};
                SHIFTL: {carry_d, acc_d} = {acc_q, fill};
                ASHR:   {acc_d, carry_d} = {acc_q[WIDTH-1], acc_q};
                ROTR:   {acc_d, carry_d} = {acc_q[0], acc_q};
                ROTL:   {carry_d, acc_d} = {acc_q, acc_q[WIDTH-1]};
                // A zero-length shift-by-N leaves everything untouched.
                SHIFTRN, SHIFTLN: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign bus.acumulador = acc_q;
    assign bus.carry      = carry_q;
    assign bus.zero       = (acc_q == '0);
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_acc_register.sv
// tb_acc_register: scoreboard bench for acc_register at WIDTH=8.
// The driver applies one opcode per clock, advances a behavioural model and
// queues the expected outputs; a monitor on the falling edge pops and compares.
module tb_acc_register;
    import acc_pkg::*;

    localparam int WIDTH = 8;
    localparam int SHW   = $clog2(WIDTH + 1);

    logic clock = 1'b0;
    logic reset_n;

    acc_register_if #(.WIDTH(WIDTH)) bus();

    acc_register #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] acc;
        logic       carry;
        logic       zero;
        logic       busy;
        logic       done;
        logic [3:0] op;
        int         step;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   step_no       = 0;

    // Reference model: value, carry and how many shift-by-N steps remain.
    logic [7:0] m_acc;
    logic       m_carry;
    int         m_remain;
    logic       m_left;

    function automatic void shiftOne(input logic left, input logic fill);
        if (left) begin
            m_carry = m_acc[7];
            m_acc   = (m_acc << 1) | {7'd0, fill};
        end else begin
            m_carry = m_acc[0];
            m_acc   = (m_acc >> 1) | {fill, 7'd0};
        end
    endfunction

    function automatic logic modelStep(input logic [3:0] op, input logic [7:0] data,
                                       input logic [SHW-1:0] sh, input logic fill);
        logic done_now;
        int   n;
        done_now = 1'b0;
        if (m_remain > 0) begin
            if (op == CLEAR) begin
                m_acc    = 8'd0;
                m_carry  = 1'b0;
                m_remain = 0;
            end else begin
                shiftOne(m_left, fill);
                m_remain = m_remain - 1;
                done_now = (m_remain == 0);
            end
        end else begin
            case (op)
                CLEAR:  begin m_acc = 8'd0; m_carry = 1'b0; end
                LOAD:   begin m_acc = data; m_carry = 1'b0; end
                SHIFTR: shiftOne(1'b0, fill);
                SHIFTL: shiftOne(1'b1, fill);
                ASHR: begin
                    m_carry = m_acc[0];
                    m_acc   = $unsigned($signed(m_acc) >>> 1);
                end
                ROTR: begin
                    m_carry = m_acc[0];
                    m_acc   = (m_acc >> 1) | (m_acc << 7);
                end
                ROTL: begin
                    m_carry = m_acc[7];
                    m_acc   = (m_acc << 1) | (m_acc >> 7);
                end
                SHIFTRN, SHIFTLN: begin
                    n      = (int'(sh) > WIDTH) ? WIDTH : int'(sh);
                    m_left = (op == SHIFTLN);
                    if (n == 0) begin
                        done_now = 1'b1;
                    end else begin
                        shiftOne(m_left, fill);
                        m_remain = n - 1;
                        done_now = (m_remain == 0);
                    end
                end
                default: ;
            endcase
        end
        return done_now;
    endfunction

    function automatic void pushExpected(input logic [3:0] op, input logic done_now);
        exp_t e;
        e.acc   = m_acc;
        e.carry = m_carry;
        e.zero  = (m_acc == 8'd0);
        e.busy  = (m_remain > 0);
        e.done  = done_now;
        e.op    = op;
        e.step  = step_no;
        step_no = step_no + 1;
        sb_q.push_back(e);
    endfunction

    function automatic void pushReset();
        m_acc    = 8'd0;
        m_carry  = 1'b0;
        m_remain = 0;
        pushExpected(4'd15, 1'b0);
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] data,
                                 input logic [SHW-1:0] sh, input logic sin);
        logic fill;
        logic done_now;
        bus.ty        = op;
        bus.ulaout    = data;
        bus.shamt     = sh;
        bus.serial_in = sin;
`ifdef ACC_SERIAL_IN_EN
        fill = sin;
`else
        fill = 1'b0;
`endif
        @(posedge clock);
        #1;
        done_now = modelStep(op, data, sh, fill);
        pushExpected(op, done_now);
    endtask

    // Drive junk (never CLEAR) until the model says the shift has finished.
    task automatic runOutShift();
        while (m_remain > 0) begin
            applyStimulus(4'($urandom_range(1, 15)), 8'($urandom), SHW'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks_total = checks_total + 1;
        if (bus.acumulador === e.acc && bus.carry === e.carry && bus.zero === e.zero &&
            bus.busy === e.busy && bus.done === e.done) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("[TB] FAIL step%0d op%0d: got acc=%02h carry=%b zero=%b busy=%b done=%b, expected acc=%02h carry=%b zero=%b busy=%b done=%b",
                     e.step, e.op, bus.acumulador, bus.carry, bus.zero, bus.busy, bus.done,
                     e.acc, e.carry, e.zero, e.busy, e.done);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is one comparison.
    always @(negedge clock) begin
        if (sb_q.size() != 0) begin
            checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        reset_n       = 1'b0;
        bus.ty        = HOLD;
        bus.ulaout    = 8'd0;
        bus.shamt     = '0;
        bus.serial_in = 1'b0;
        m_acc         = 8'd0;
        m_carry       = 1'b0;
        m_remain      = 0;
        m_left        = 1'b0;

        repeat (2) begin
            @(posedge clock);
            #1;
            pushReset();
        end
        reset_n = 1'b1;

        // Basic ops
        applyStimulus(LOAD,   8'h96, 0, 0);
        applyStimulus(SHIFTR, 8'h00, 0, 0);
        applyStimulus(LOAD,   8'h96, 0, 0);
        applyStimulus(ASHR,   8'h00, 0, 0);
        applyStimulus(CLEAR,  8'h5A, 0, 0);

        // Rotates, carry and an unnamed opcode
        applyStimulus(LOAD,   8'h81, 0, 0);
        applyStimulus(ROTL,   8'h00, 0, 0);
        applyStimulus(ROTR,   8'h00, 0, 0);
        applyStimulus(4'd12,  8'hFF, 0, 0);
        applyStimulus(SHIFTL, 8'h00, 0, 0);

        // Shift-by-N: shamt 3, then shamt 0, then shamt 1 right after done
        applyStimulus(LOAD,    8'hF0, 0, 0);
        applyStimulus(SHIFTRN, 8'h00, 3, 0);
        runOutShift();
        applyStimulus(SHIFTRN, 8'h00, 0, 0);
        applyStimulus(SHIFTLN, 8'h00, 1, 0);
        applyStimulus(HOLD,    8'h00, 0, 0);

        // Clamp to WIDTH, then CLEAR abort on the third edge of a run
        applyStimulus(LOAD,    8'hFF, 0, 0);
        applyStimulus(SHIFTLN, 8'h00, 15, 0);
        runOutShift();
        applyStimulus(LOAD,    8'hFF, 0, 0);
        applyStimulus(SHIFTLN, 8'h00, 15, 0);
        applyStimulus(ROTR,    8'h00, 0, 0);
        applyStimulus(CLEAR,   8'h00, 0, 0);
        applyStimulus(HOLD,    8'h00, 0, 0);

        // Serial fill on an empty register
        applyStimulus(SHIFTR,  8'h00, 0, 1);

        // Asynchronous reset between edges in the middle of a shift-by-N
        applyStimulus(LOAD,    8'hA5, 0, 0);
        applyStimulus(SHIFTRN, 8'h00, 5, 0);
        bus.ty = HOLD;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        pushReset();
        @(posedge clock);
        #1;
        pushReset();
        reset_n = 1'b1;

        // Randomised traffic, with occasional aborts during shift-by-N runs
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), SHW'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            while (m_remain > 0) begin
                applyStimulus(($urandom_range(0, 9) == 0) ? CLEAR : 4'($urandom_range(1, 15)),
                              8'($urandom), SHW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clock);
        #1;
        checks_total = checks_total + 1;
        if (sb_q.size() == 0) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("[TB] FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
